// File: rtl/cnn_layer_sequencer.sv
// ----------------------------------------------------------------------------
// cnn_layer_sequencer
//
// Network-level sequencer for the convolution controller. It holds a
// runtime-programmable table of up to NUM_LAYERS layer descriptors and walks
// through them one layer at a time:
//   - issues one start pulse per layer, START_DLY cycles after entering LAUNCH
//   - treats the falling edge of i_picture_finish as "layer done"
//   - pulses o_cnn_finish after the last layer, or o_cnn_aborted on abort
//
// Optional feature (macro CNN_SEQ_CHAIN_ADDR_EN):
//   When defined, layers >= 1 take their input base address from the previous
//   layer's output base address. The programmed inaddr of those layers is
//   still stored but is not driven. Layer 0 always uses its own inaddr.
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-low reset
//   i_cnn_start         run request, sampled in IDLE only
//   i_abort             abort the run (level, ignored in IDLE)
//   i_picture_finish    controller layer-done level
//   i_cfg_we/layer/sel/wdata  descriptor write port (IDLE only)
//   o_cfg_err           one-cycle pulse when a write is rejected
//   o_start             one-cycle start pulse to the controller
//   o_do .. o_outaddr   geometry / base addresses of the active layer
//   o_cur_layer         active layer index
//   o_busy              high in LAUNCH and RUN
//   o_cnn_finish        one-cycle pulse on normal completion
//   o_cnn_aborted       one-cycle pulse on abort
//
// cfg_sel map: 0 do, 1 di, 2 dr, 3 dc, 4 dkc, 5 dkr, 6 filter_size,
//   7 di_out, 8 dr_out, 9 dc_out, 10 inaddr, 11 waddr, 12 outaddr,
//   13 num_layers (global).
// ----------------------------------------------------------------------------
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int LW         = 2,
    parameter int AW         = 13,
    parameter int FSW        = 8,
    parameter int START_DLY  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cnn_start,
    input  logic            i_abort,
    input  logic            i_picture_finish,
    input  logic            i_cfg_we,
    input  logic [LW-1:0]   i_cfg_layer,
    input  logic [3:0]      i_cfg_sel,
    input  logic [AW-1:0]   i_cfg_wdata,
    output logic            o_cfg_err,
    output logic            o_start,
    output logic [AW-1:0]   o_do,
    output logic [AW-1:0]   o_di,
    output logic [AW-1:0]   o_dr,
    output logic [AW-1:0]   o_dc,
    output logic [AW-1:0]   o_dkc,
    output logic [AW-1:0]   o_dkr,
    output logic [FSW-1:0]  o_filter_size,
    output logic [AW-1:0]   o_di_out,
    output logic [AW-1:0]   o_dr_out,
    output logic [AW-1:0]   o_dc_out,
    output logic [AW-1:0]   o_inaddr,
    output logic [AW-1:0]   o_waddr,
    output logic [AW-1:0]   o_outaddr,
    output logic [LW-1:0]   o_cur_layer,
    output logic            o_busy,
    output logic            o_cnn_finish,
    output logic            o_cnn_aborted
);

    localparam int NFIELDS = 13;
    localparam int NLW     = $clog2(NUM_LAYERS + 1);

    localparam int F_DO = 0, F_DI = 1, F_DR = 2, F_DC = 3, F_DKC = 4, F_DKR = 5;
    localparam int F_FS = 6, F_DI_OUT = 7, F_DR_OUT = 8, F_DC_OUT = 9;
    localparam int F_INADDR = 10, F_WADDR = 11, F_OUTADDR = 12;

    localparam logic [AW-1:0] FS_MASK = AW'((64'd1 << FSW) - 64'd1);
    localparam logic [3:0]    DLY     = 4'(START_DLY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic [LW-1:0]      r_cur_layer;
    logic [LW-1:0]      w_layer_next;
    logic               r_pf_d;
    logic               r_finish;
    logic               w_finish_next;
    logic               r_aborted;
    logic               w_aborted_next;
    logic               r_cfg_err;
    logic [NLW-1:0]     r_num_layers;
    logic [AW-1:0]      r_desc [NUM_LAYERS][NFIELDS];

    logic               w_busy;
    logic               w_done_evt;
    logic               w_last_layer;
    logic               w_start;
    logic               w_sel_field;
    logic               w_sel_nl;
    logic               w_reject;
    logic               w_wr_ok;
    logic [AW-1:0]      w_wr_val;
    logic [AW-1:0]      w_cur [NFIELDS];
    logic [AW-1:0]      w_inaddr;

    assign w_busy       = (r_state != S_IDLE);
    assign w_done_evt   = r_pf_d & ~i_picture_finish;
    assign w_last_layer = (int'(r_cur_layer) + 1 == int'(r_num_layers));

    // ------------------------------------------------------------------
    // Descriptor write qualification
    // ------------------------------------------------------------------
    assign w_sel_field = (i_cfg_sel <= 4'd12);
    assign w_sel_nl    = (i_cfg_sel == 4'd13);
    assign w_reject    = w_busy
                       || (i_cfg_sel > 4'd13)
                       || (w_sel_field && (int'(i_cfg_layer) >= NUM_LAYERS))
                       || (w_sel_nl && (i_cfg_wdata > AW'(NUM_LAYERS)));
    assign w_wr_ok     = i_cfg_we && !w_reject;
    // filter_size keeps only its low FSW bits so the stored value matches
    // what is driven out.
    assign w_wr_val    = (i_cfg_sel == 4'(F_FS)) ? (i_cfg_wdata & FS_MASK) : i_cfg_wdata;

    // ------------------------------------------------------------------
    // State and table registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cur_layer  <= '0;
            r_pf_d       <= 1'b0;
            r_finish     <= 1'b0;
            r_aborted    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_num_layers <= NLW'(NUM_LAYERS);
            for (int l = 0; l < NUM_LAYERS; l++) begin
                for (int f = 0; f < NFIELDS; f++) begin
                    r_desc[l][f] <= '0;
                end
            end
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cur_layer <= w_layer_next;
            r_pf_d      <= i_picture_finish;
            r_finish    <= w_finish_next;
            r_aborted   <= w_aborted_next;
            r_cfg_err   <= i_cfg_we && w_reject;
            if (w_wr_ok) begin
                if (w_sel_field) begin
                    r_desc[i_cfg_layer][i_cfg_sel] <= w_wr_val;
                end else begin
                    r_num_layers <= NLW'(i_cfg_wdata);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_layer_next   = r_cur_layer;
        w_finish_next  = 1'b0;
        w_aborted_next = 1'b0;
        w_start        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_cnn_start) begin
                    if (r_num_layers != '0) begin
                        w_state_next = S_LAUNCH;
                        w_layer_next = '0;
                        w_cnt_next   = '0;
                    end else begin
                        // Empty network: report completion without launching.
                        w_finish_next = 1'b1;
                    end
                end
            end

            S_LAUNCH: begin
                if (i_abort) begin
                    // Abort also suppresses a start due in this same cycle.
                    w_state_next   = S_IDLE;
                    w_layer_next   = '0;
                    w_aborted_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                    if (r_cnt == DLY) begin
                        w_start      = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (i_abort) begin
                    w_state_next   = S_IDLE;
                    w_layer_next   = '0;
                    w_aborted_next = 1'b1;
                end else if (w_done_evt) begin
                    if (w_last_layer) begin
                        w_state_next  = S_IDLE;
                        w_layer_next  = '0;
                        w_finish_next = 1'b1;
                    end else begin
                        w_state_next = S_LAUNCH;
                        w_layer_next = r_cur_layer + LW'(1);
                        w_cnt_next   = '0;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_layer_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Active-layer parameter outputs, forced to zero in IDLE
    // ------------------------------------------------------------------
    always_comb begin
        for (int f = 0; f < NFIELDS; f++) begin
            w_cur[f] = w_busy ? r_desc[r_cur_layer][f] : '0;
        end
    end

`ifdef CNN_SEQ_CHAIN_ADDR_EN
    // Layers after the first read the feature map the previous layer wrote.
    always_comb begin
        w_inaddr = w_cur[F_INADDR];
        if (w_busy && (r_cur_layer != '0)) begin
            w_inaddr = r_desc[r_cur_layer - LW'(1)][F_OUTADDR];
        end
    end
`else
    assign w_inaddr = w_cur[F_INADDR];
`endif

    assign o_do          = w_cur[F_DO];
    assign o_di          = w_cur[F_DI];
    assign o_dr          = w_cur[F_DR];
    assign o_dc          = w_cur[F_DC];
    assign o_dkc         = w_cur[F_DKC];
    assign o_dkr         = w_cur[F_DKR];
    assign o_filter_size = FSW'(w_cur[F_FS]);
    assign o_di_out      = w_cur[F_DI_OUT];
    assign o_dr_out      = w_cur[F_DR_OUT];
    assign o_dc_out      = w_cur[F_DC_OUT];
    assign o_inaddr      = w_inaddr;
    assign o_waddr       = w_cur[F_WADDR];
    assign o_outaddr     = w_cur[F_OUTADDR];
    assign o_cur_layer   = w_busy ? r_cur_layer : '0;
    assign o_busy        = w_busy;
    assign o_start       = w_start;
    assign o_cnn_finish  = r_finish;
    assign o_cnn_aborted = r_aborted;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cnn_layer_sequencer
//
// Directed testbench for cnn_layer_sequencer with default parameters
// (NUM_LAYERS=4, LW=2, AW=13, FSW=8, START_DLY=2). Inputs are driven just
// after the falling clock edge and outputs are sampled there too, so every
// observed value is half a period away from the active edge.
// ----------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

    localparam int NUM_LAYERS = 4;
    localparam int LW         = 2;
    localparam int AW         = 13;
    localparam int FSW        = 8;
    localparam int START_DLY  = 2;

    logic            clk;
    logic            rst;
    logic            i_cnn_start;
    logic            i_abort;
    logic            i_picture_finish;
    logic            i_cfg_we;
    logic [LW-1:0]   i_cfg_layer;
    logic [3:0]      i_cfg_sel;
    logic [AW-1:0]   i_cfg_wdata;
    logic            o_cfg_err;
    logic            o_start;
    logic [AW-1:0]   o_do, o_di, o_dr, o_dc, o_dkc, o_dkr;
    logic [FSW-1:0]  o_filter_size;
    logic [AW-1:0]   o_di_out, o_dr_out, o_dc_out;
    logic [AW-1:0]   o_inaddr, o_waddr, o_outaddr;
    logic [LW-1:0]   o_cur_layer;
    logic            o_busy;
    logic            o_cnn_finish;
    logic            o_cnn_aborted;

    int n_checks = 0;
    int n_fail   = 0;

    cnn_layer_sequencer #(
        .NUM_LAYERS (NUM_LAYERS),
        .LW         (LW),
        .AW         (AW),
        .FSW        (FSW),
        .START_DLY  (START_DLY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cnn_start      (i_cnn_start),
        .i_abort          (i_abort),
        .i_picture_finish (i_picture_finish),
        .i_cfg_we         (i_cfg_we),
        .i_cfg_layer      (i_cfg_layer),
        .i_cfg_sel        (i_cfg_sel),
        .i_cfg_wdata      (i_cfg_wdata),
        .o_cfg_err        (o_cfg_err),
        .o_start          (o_start),
        .o_do             (o_do),
        .o_di             (o_di),
        .o_dr             (o_dr),
        .o_dc             (o_dc),
        .o_dkc            (o_dkc),
        .o_dkr            (o_dkr),
        .o_filter_size    (o_filter_size),
        .o_di_out         (o_di_out),
        .o_dr_out         (o_dr_out),
        .o_dc_out         (o_dc_out),
        .o_inaddr         (o_inaddr),
        .o_waddr          (o_waddr),
        .o_outaddr        (o_outaddr),
        .o_cur_layer      (o_cur_layer),
        .o_busy           (o_busy),
        .o_cnn_finish     (o_cnn_finish),
        .o_cnn_aborted    (o_cnn_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic cfg_write(input int layer, input int sel, input int data);
        i_cfg_we    = 1'b1;
        i_cfg_layer = LW'(layer);
        i_cfg_sel   = 4'(sel);
        i_cfg_wdata = AW'(data);
        @(negedge clk);
        i_cfg_we    = 1'b0;
        $display("cfg write: layer=%0d sel=%0d data=%0d -> cfg_err=%0b", layer, sel, data, o_cfg_err);
    endtask

    // Pulse cnn_start for one cycle; returns in the first cycle after the
    // sampling edge.
    task automatic launch();
        i_cnn_start = 1'b1;
        @(negedge clk);
        i_cnn_start = 1'b0;
    endtask

    // Counts cycles (1 = current cycle) until start is seen; 0 on timeout.
    task automatic wait_start(output int lat);
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            if (o_start === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        $display("start seen: latency=%0d layer=%0d dr=%0d", lat, o_cur_layer, o_dr);
    endtask

    // picture_finish high 5 cycles then low; returns in the cycle after the
    // falling edge was sampled.
    task automatic layer_done();
        i_picture_finish = 1'b1;
        repeat (5) @(negedge clk);
        i_picture_finish = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        i_cnn_start = 1'b0; i_abort = 1'b0; i_picture_finish = 1'b0;
        i_cfg_we = 1'b0; i_cfg_layer = '0; i_cfg_sel = '0; i_cfg_wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
        n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b expected 0", o_start); end
        n_checks++; if (o_dr !== 0 || o_outaddr !== 0) begin n_fail++; $display("FAIL reset_params: dr=%0d outaddr=%0d expected 0", o_dr, o_outaddr); end
        n_checks++; if ({o_cnn_finish, o_cnn_aborted, o_cfg_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {o_cnn_finish, o_cnn_aborted, o_cfg_err}); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_two_layer_run();
        int lat;
        cfg_write(0, 0, 4);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL good_write_err: got %0b expected 0", o_cfg_err); end
        cfg_write(0, 1, 1);
        cfg_write(0, 2, 28);
        cfg_write(0, 10, 1);
        cfg_write(0, 12, 1000);
        cfg_write(1, 1, 4);
        cfg_write(1, 2, 13);
        cfg_write(1, 10, 1000);
        cfg_write(1, 12, 3000);
        cfg_write(0, 13, 2);

        launch();
        n_checks++; if (o_busy !== 1'b1 || o_start !== 1'b0) begin n_fail++; $display("FAIL launch_enter: busy=%0b start=%0b expected 1/0", o_busy, o_start); end
        wait_start(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL l0_start_latency: got %0d expected 3", lat); end
        n_checks++; if (o_dr !== 28 || o_do !== 4 || o_di !== 1) begin n_fail++; $display("FAIL l0_geom: do=%0d di=%0d dr=%0d expected 4/1/28", o_do, o_di, o_dr); end
        n_checks++; if (o_inaddr !== 1 || o_outaddr !== 1000) begin n_fail++; $display("FAIL l0_addr: in=%0d out=%0d expected 1/1000", o_inaddr, o_outaddr); end
        @(negedge clk);
        n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL l0_start_width: got %0b expected 0", o_start); end

        layer_done();
        n_checks++; if (o_cur_layer !== 1 || o_dr !== 13) begin n_fail++; $display("FAIL l1_switch: layer=%0d dr=%0d expected 1/13", o_cur_layer, o_dr); end
        wait_start(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL l1_start_latency: got %0d expected 3", lat); end
        n_checks++; if (o_di !== 4 || o_inaddr !== 1000 || o_outaddr !== 3000) begin n_fail++; $display("FAIL l1_fields: di=%0d in=%0d out=%0d expected 4/1000/3000", o_di, o_inaddr, o_outaddr); end
        @(negedge clk);

        cfg_write(1, 2, 99);
        n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL busy_write_err: got %0b expected 1", o_cfg_err); end
        n_checks++; if (o_dr !== 13) begin n_fail++; $display("FAIL busy_write_nochange: dr=%0d expected 13", o_dr); end
        @(negedge clk);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL busy_err_width: got %0b expected 0", o_cfg_err); end

        layer_done();
        n_checks++; if (o_cnn_finish !== 1'b1 || o_cnn_aborted !== 1'b0) begin n_fail++; $display("FAIL run_finish: finish=%0b aborted=%0b expected 1/0", o_cnn_finish, o_cnn_aborted); end
        n_checks++; if (o_busy !== 1'b0 || o_dr !== 0 || o_outaddr !== 0 || o_cur_layer !== 0) begin n_fail++; $display("FAIL idle_outputs: busy=%0b dr=%0d out=%0d layer=%0d expected 0", o_busy, o_dr, o_outaddr, o_cur_layer); end
        @(negedge clk);
        n_checks++; if (o_cnn_finish !== 1'b0) begin n_fail++; $display("FAIL finish_width: got %0b expected 0", o_cnn_finish); end
    endtask

    task automatic test_cfg_errors();
        cfg_write(0, 14, 5);
        n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL bad_sel_err: got %0b expected 1", o_cfg_err); end
        cfg_write(0, 13, 5);
        n_checks++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL bad_numlayers_err: got %0b expected 1", o_cfg_err); end
        cfg_write(0, 13, 4);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL max_numlayers_err: got %0b expected 0", o_cfg_err); end
    endtask

    task automatic test_zero_layers();
        cfg_write(0, 13, 0);
        n_checks++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL zero_write_err: got %0b expected 0", o_cfg_err); end
        launch();
        n_checks++; if (o_cnn_finish !== 1'b1 || o_busy !== 1'b0 || o_start !== 1'b0) begin n_fail++; $display("FAIL zero_finish: finish=%0b busy=%0b start=%0b expected 1/0/0", o_cnn_finish, o_busy, o_start); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if ({o_start, o_busy, o_cnn_finish} !== 3'b000) begin n_fail++; $display("FAIL zero_quiet: cycle %0d start/busy/finish=%b expected 000", k, {o_start, o_busy, o_cnn_finish}); end
        end
    endtask

    task automatic test_abort();
        int lat;
        cfg_write(0, 13, 3);
        launch();
        wait_start(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL abort_run_latency: got %0d expected 3", lat); end
        @(negedge clk);
        i_picture_finish = 1'b1;
        repeat (3) @(negedge clk);
        // Falling edge of picture_finish and abort together on layer 0.
        i_picture_finish = 1'b0;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        n_checks++; if (o_cnn_aborted !== 1'b1 || o_cnn_finish !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: aborted=%0b finish=%0b expected 1/0", o_cnn_aborted, o_cnn_finish); end
        n_checks++; if (o_busy !== 1'b0 || o_cur_layer !== 0) begin n_fail++; $display("FAIL abort_idle: busy=%0b layer=%0d expected 0/0", o_busy, o_cur_layer); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if ({o_start, o_cnn_finish, o_cnn_aborted, o_busy} !== 4'b0000) begin n_fail++; $display("FAIL abort_quiet: cycle %0d start/finish/aborted/busy=%b expected 0000", k, {o_start, o_cnn_finish, o_cnn_aborted, o_busy}); end
        end

        // Abort landing on the cycle where start would fire.
        launch();
        repeat (2) @(negedge clk);
        i_abort = 1'b1;
        #1;
        n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL abort_suppress_start: got %0b expected 0", o_start); end
        @(negedge clk);
        i_abort = 1'b0;
        n_checks++; if (o_cnn_aborted !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL launch_abort: aborted=%0b busy=%0b expected 1/0", o_cnn_aborted, o_busy); end

        // Abort in IDLE does nothing.
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        n_checks++; if (o_cnn_aborted !== 1'b0) begin n_fail++; $display("FAIL idle_abort: got %0b expected 0", o_cnn_aborted); end
    endtask

    task automatic test_chain_addr_and_reset();
        int lat;
        int exp_in;
`ifdef CNN_SEQ_CHAIN_ADDR_EN
        exp_in = 1000;
`else
        exp_in = 7;
`endif
        cfg_write(1, 10, 7);
        cfg_write(0, 13, 2);
        launch();
        wait_start(lat);
        n_checks++; if (o_inaddr !== 1) begin n_fail++; $display("FAIL chain_l0_inaddr: got %0d expected 1", o_inaddr); end
        @(negedge clk);
        layer_done();
        wait_start(lat);
        n_checks++; if (o_inaddr !== AW'(exp_in)) begin n_fail++; $display("FAIL chain_l1_inaddr: got %0d expected %0d", o_inaddr, exp_in); end
        @(negedge clk);

        // Reset in RUN on layer 1.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (o_busy !== 1'b0 || o_cur_layer !== 0 || o_start !== 1'b0) begin n_fail++; $display("FAIL midreset_state: busy=%0b layer=%0d start=%0b expected 0", o_busy, o_cur_layer, o_start); end
        n_checks++; if (o_cnn_finish !== 1'b0 || o_cnn_aborted !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: finish=%0b aborted=%0b expected 0/0", o_cnn_finish, o_cnn_aborted); end
        @(negedge clk);
        n_checks++; if (o_cnn_finish !== 1'b0 || o_cnn_aborted !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses2: finish=%0b aborted=%0b expected 0/0", o_cnn_finish, o_cnn_aborted); end

        // Table must be zero and num_layers back to 4.
        launch();
        wait_start(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL postreset_latency: got %0d expected 3", lat); end
        n_checks++; if (o_dr !== 0 || o_do !== 0 || o_di !== 0 || o_outaddr !== 0 || o_inaddr !== 0) begin n_fail++; $display("FAIL table_zeroed: do=%0d di=%0d dr=%0d in=%0d out=%0d expected 0", o_do, o_di, o_dr, o_inaddr, o_outaddr); end
        for (int l = 1; l < NUM_LAYERS; l++) begin
            @(negedge clk);
            layer_done();
            n_checks++; if (o_cur_layer !== LW'(l) || o_cnn_finish !== 1'b0) begin n_fail++; $display("FAIL postreset_layer: layer=%0d finish=%0b expected %0d/0", o_cur_layer, o_cnn_finish, l); end
            wait_start(lat);
        end
        @(negedge clk);
        layer_done();
        n_checks++; if (o_cnn_finish !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL four_layer_finish: finish=%0b busy=%0b expected 1/0", o_cnn_finish, o_busy); end
    endtask

    initial begin
        test_reset();
        test_two_layer_run();
        test_cfg_errors();
        test_zero_layers();
        test_abort();
        test_chain_addr_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Generalised network-level sequencer for the convolution controller. It replaces the fixed two-layer IDLE/CONV1/CONV2 top-level FSM.
- Holds a runtime-programmable descriptor table of up to NUM_LAYERS layers and drives the active layer's geometry and BRAM base addresses to the controller.
- Issues one start pulse per layer, detects layer completion on the falling edge of picture_finish, and signals network completion or abort.

Parameters:
- NUM_LAYERS, 4, descriptor table depth; minimum 1.
- LW, 2, layer index width; must satisfy 2^LW >= NUM_LAYERS.
- AW, 13, width of dimension and address fields.
- FSW, 8, width of filter_size.
- START_DLY, 2, cycles from entering LAUNCH to the start pulse; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cnn_start  in  1  run request; sampled in IDLE only
- abort  in  1  terminate the run; level-sampled
- picture_finish  in  1  controller layer-done level; its falling edge marks layer completion
- cfg_we  in  1  descriptor write strobe
- cfg_layer  in  LW  layer index for cfg writes
- cfg_sel  in  4  field select for cfg writes
- cfg_wdata  in  AW  write data
- cfg_err  out  1  one-cycle pulse when a write is rejected
- start  out  1  one-cycle start pulse to the controller
- do, di, dr, dc, dkc, dkr  out  AW each  active layer geometry
- filter_size  out  FSW  active layer kernel size
- di_out, dr_out, dc_out  out  AW each  active layer output geometry
- inaddr, waddr, outaddr  out  AW each  active layer BRAM base addresses
- cur_layer  out  LW  active layer index
- busy  out  1  high in every state except IDLE
- cnn_finish  out  1  one-cycle pulse on normal completion
- cnn_aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset (rst low at a clk edge):
  - state IDLE, all descriptor fields 0, num_layers = NUM_LAYERS.
  - All outputs 0.
  - Reset mid-run abandons the run and generates no finish or abort pulse.
- cfg_sel field map: 0 do, 1 di, 2 dr, 3 dc, 4 dkc, 5 dkr, 6 filter_size (low FSW bits), 7 di_out, 8 dr_out, 9 dc_out, 10 inaddr, 11 waddr, 12 outaddr, 13 num_layers (global; cfg_layer ignored).
- A write is rejected, with no state change and cfg_err pulsed the next cycle, when any of these hold:
  - busy = 1;
  - cfg_sel > 13;
  - cfg_layer >= NUM_LAYERS, for fields 0..12;
  - cfg_wdata > NUM_LAYERS, for field 13.
- Accepted writes take effect on the next edge.
- Parameter outputs are combinational from descriptor[cur_layer] while busy, and 0 in IDLE.
- pf_d is a registered copy of picture_finish. done_evt = pf_d & ~picture_finish.
- States: IDLE, LAUNCH, RUN.
- IDLE:
  - cnn_start=1 and num_layers>0: go to LAUNCH, cur_layer=0, launch counter=0.
  - cnn_start=1 and num_layers==0: pulse cnn_finish next cycle and stay in IDLE.
  - cnn_start while busy is ignored.
- LAUNCH:
  - Counter increments each cycle.
  - start=1 (registered-free decode) in the cycle the counter equals START_DLY; go to RUN on the next edge.
  - With START_DLY=0, start is high in the first LAUNCH cycle.
  - Start timing: cnn_start sampled at edge T puts the start pulse in cycle T+1+START_DLY.
- RUN:
  - On done_evt with cur_layer < num_layers-1: cur_layer++ and go to LAUNCH (counter=0).
  - On done_evt with cur_layer == num_layers-1: go to IDLE and pulse cnn_finish in the first IDLE cycle.
  - A falling edge of picture_finish in LAUNCH is ignored.
- abort=1 in LAUNCH or RUN: go to IDLE next edge, pulse cnn_aborted, suppress start in that cycle.
  - Abort wins over a simultaneous done_evt.
  - abort in IDLE is ignored.
- cnn_finish and cnn_aborted are never high together.

Optional Feature:
- Macro CNN_SEQ_CHAIN_ADDR_EN.
- When defined: for cur_layer >= 1, inaddr = outaddr of descriptor[cur_layer-1]. Programmed inaddr of layers >= 1 is stored but not driven. Layer 0 uses its programmed inaddr.
- When undefined: inaddr always comes from descriptor[cur_layer].

Test Plan:
- Program layer0 (do=4, di=1, dr=28, inaddr=1, outaddr=1000) and layer1 (di=4, dr=13, inaddr=1000, outaddr=3000); num_layers=2; START_DLY=2; pulse cnn_start at edge T.
  - Expect start in cycle T+3 with dr=28.
  - Drive picture_finish high 5 cycles then low at cycle F: cur_layer=1, dr=13, start at F+3.
  - Second falling edge at G: cnn_finish at G+1, all outputs 0.
- Write during busy (cfg_sel=2, data=99): cfg_err pulse, layer dr unchanged.
- Write with cfg_sel=14: cfg_err pulse.
- Write num_layers=5 with NUM_LAYERS=4: cfg_err pulse.
- num_layers=0, cnn_start: cnn_finish one cycle later, start never asserted, busy stays 0.
- abort asserted in the same cycle as a picture_finish falling edge on layer 0 of 3: cnn_aborted pulse, no cnn_finish, no further start, back in IDLE.
- With CNN_SEQ_CHAIN_ADDR_EN, layer0 outaddr=1000 and layer1 programmed inaddr=7: inaddr=1000 during layer 1. Without the macro: inaddr=7.
- Synchronous reset asserted mid-RUN on layer 1: next cycle busy=0, cur_layer=0, table zeroed, num_layers=4, no pulses.
